// File: rtl/alu_pkg.sv
// ----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the ALU and its operand sequencer:
//   DATA_W       default operand/result width
//   FN_*         ALU CtrlFunc encodings
//   FLG_*        ALU Flags encodings
//   seq_state_e  operand sequencer FSM states
// ----------------------------------------------------------------------------
package alu_pkg;

   localparam int DATA_W = 32;

   localparam logic [2:0] FN_AND   = 3'b000;
   localparam logic [2:0] FN_OR    = 3'b001;
   localparam logic [2:0] FN_XOR   = 3'b010;
   localparam logic [2:0] FN_ADD   = 3'b011;
   localparam logic [2:0] FN_SUB   = 3'b100;
   localparam logic [2:0] FN_CMP   = 3'b101;
   localparam logic [2:0] FN_MUL   = 3'b110;
   localparam logic [2:0] FN_SHL16 = 3'b111;

   localparam logic [1:0] FLG_POS  = 2'b00;
   localparam logic [1:0] FLG_ZERO = 2'b01;
   localparam logic [1:0] FLG_NEG  = 2'b10;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_WB   = 2'd2
   } seq_state_e;

endpackage

// File: rtl/alu_op_sequencer.sv
// ----------------------------------------------------------------------------
// alu_op_sequencer
// Initiator side of the ALU operand/function interface. Accepts one decoded op,
// drives registered operands/function to the external combinational ALU, holds
// them for the op's latency, then either offers a register writeback or (for
// CMP) updates the architectural flags.
//
// Ports
//   clk, rst_n             clock, asynchronous active-low reset
//   in_valid/in_ready      op handshake from decode (ready only in IDLE)
//   in_func/in_a/in_b/in_rd  op function, operands, destination register
//   alu_a/alu_b/alu_func   registered drive to the ALU
//   alu_result/alu_flags   combinational ALU response
//   wb_valid/wb_ready      writeback handshake to the register file
//   wb_rd/wb_data          writeback index and value
//   flags                  architectural flags, written by CMP only
//   busy                   high whenever not IDLE
// ----------------------------------------------------------------------------
module alu_op_sequencer #(
   parameter int DATA_W  = alu_pkg::DATA_W,
   parameter int RD_W    = 4,
   parameter int MUL_LAT = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [2:0]        in_func,
   input  logic [DATA_W-1:0] in_a,
   input  logic [DATA_W-1:0] in_b,
   input  logic [RD_W-1:0]   in_rd,
   output logic [DATA_W-1:0] alu_a,
   output logic [DATA_W-1:0] alu_b,
   output logic [2:0]        alu_func,
   input  logic [DATA_W-1:0] alu_result,
   input  logic [1:0]        alu_flags,
   output logic              wb_valid,
   input  logic              wb_ready,
   output logic [RD_W-1:0]   wb_rd,
   output logic [DATA_W-1:0] wb_data,
   output logic [1:0]        flags,
   output logic              busy
);

   import alu_pkg::*;

   // 4 bits covers the whole legal MUL_LAT range (1..15).
   localparam int              CNT_W   = 4;
   localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_LAT - 1);

   seq_state_e        state_q, state_d;
   logic [CNT_W-1:0]  cnt_q;
   logic [RD_W-1:0]   rd_q;
   logic [DATA_W-1:0] alu_a_q, alu_b_q, wb_data_q;
   logic [2:0]        alu_func_q;
   logic [RD_W-1:0]   wb_rd_q;
   logic              wb_valid_q;
   logic [1:0]        flags_q;

   logic accept;
   logic exec_done;
   logic wants_wb;

   assign accept    = (state_q == ST_IDLE) && in_valid;
   assign exec_done = (state_q == ST_EXEC) && (cnt_q == '0);
   // CMP and writes to register 0 complete without a writeback.
   assign wants_wb  = (alu_func_q != FN_CMP) && (rd_q != '0);

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: if (in_valid)       state_d = ST_EXEC;
         ST_EXEC: if (cnt_q == '0)    state_d = wants_wb ? ST_WB : ST_IDLE;
         ST_WB:   if (wb_ready)       state_d = ST_IDLE;
         default:                     state_d = ST_IDLE;
      endcase
   end

   // FSM outputs
   always_comb begin
      in_ready = (state_q == ST_IDLE);
      busy     = (state_q != ST_IDLE);
   end

   // Operand/function registers: loaded on accept only, so they keep the
   // last op after completion and never toggle while idle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         alu_a_q    <= '0;
         alu_b_q    <= '0;
         alu_func_q <= '0;
         rd_q       <= '0;
         cnt_q      <= '0;
      end else if (accept) begin
         alu_a_q    <= in_a;
         alu_b_q    <= in_b;
         alu_func_q <= in_func;
         rd_q       <= in_rd;
         cnt_q      <= (in_func == FN_MUL) ? MUL_CNT : '0;
      end else if ((state_q == ST_EXEC) && (cnt_q != '0)) begin
         cnt_q      <= cnt_q - 1'b1;
      end
   end

   // Result capture, writeback handshake and architectural flags
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wb_valid_q <= 1'b0;
         wb_rd_q    <= '0;
         wb_data_q  <= '0;
         flags_q    <= FLG_POS;
      end else if (exec_done) begin
         if (alu_func_q == FN_CMP) begin
            flags_q <= alu_flags;
         end else if (rd_q != '0) begin
            wb_valid_q <= 1'b1;
            wb_rd_q    <= rd_q;
            wb_data_q  <= alu_result;
         end
      end else if ((state_q == ST_WB) && wb_ready) begin
         wb_valid_q <= 1'b0;
      end
   end

   assign alu_a    = alu_a_q;
   assign alu_b    = alu_b_q;
   assign alu_func = alu_func_q;
   assign wb_valid = wb_valid_q;
   assign wb_rd    = wb_rd_q;
   assign wb_data  = wb_data_q;
   assign flags    = flags_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// ----------------------------------------------------------------------------
// tb_alu_op_sequencer
// Drives ops into alu_op_sequencer with a behavioural ALU attached, checks
// latency, operand hold, writeback handshake and flag updates against fixed
// vectors and a random op stream scored by a reference model.
// ----------------------------------------------------------------------------
module tb_alu_op_sequencer;
   import alu_pkg::*;

   localparam int DW = 32;
   localparam int RW = 4;
   localparam int ML = 2;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          in_valid;
   logic          in_ready;
   logic [2:0]    in_func;
   logic [DW-1:0] in_a, in_b;
   logic [RW-1:0] in_rd;
   logic [DW-1:0] alu_a, alu_b;
   logic [2:0]    alu_func;
   logic [DW-1:0] alu_result;
   logic [1:0]    alu_flags;
   logic          wb_valid;
   logic          wb_ready;
   logic [RW-1:0] wb_rd;
   logic [DW-1:0] wb_data;
   logic [1:0]    flags;
   logic          busy;

   int checks = 0;
   int errors = 0;
   logic [1:0] mflags;

   always #5 clk = ~clk;

   alu_op_sequencer #(.DATA_W(DW), .RD_W(RW), .MUL_LAT(ML)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_func(in_func),
      .in_a(in_a), .in_b(in_b), .in_rd(in_rd),
      .alu_a(alu_a), .alu_b(alu_b), .alu_func(alu_func),
      .alu_result(alu_result), .alu_flags(alu_flags),
      .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd), .wb_data(wb_data),
      .flags(flags), .busy(busy)
   );

   function automatic logic [DW-1:0] ref_res(logic [2:0] f, logic [DW-1:0] a, logic [DW-1:0] b);
      case (f)
         FN_AND:   return a & b;
         FN_OR:    return a | b;
         FN_XOR:   return a ^ b;
         FN_ADD:   return a + b;
         FN_MUL:   return a * b;
         FN_SHL16: return a << 16;
         default:  return a - b;   // SUB and CMP
      endcase
   endfunction

   function automatic logic [1:0] flags_of(logic [DW-1:0] r);
      if (r == '0)   return FLG_ZERO;
      if (r[DW-1])   return FLG_NEG;
      return FLG_POS;
   endfunction

   // Behavioural combinational ALU sitting on the sequencer's outputs
   always_comb begin
      alu_result = ref_res(alu_func, alu_a, alu_b);
      alu_flags  = flags_of(alu_result);
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Issues one op and follows it cycle by cycle to completion.
   task automatic run_op(input logic [2:0] f, input logic [DW-1:0] a, input logic [DW-1:0] b,
                         input logic [RW-1:0] rd, input int wt, input bit junk,
                         input bit exp_wb, input logic [DW-1:0] exp_data,
                         input logic [1:0] exp_flags);
      int lat;
      lat = (f == FN_MUL) ? 1 + ML : 2;
      @(negedge clk);
      chk("in_ready_idle", in_ready, 1'b1);
      in_valid = 1'b1; in_func = f; in_a = a; in_b = b; in_rd = rd; wb_ready = 1'b0;
      @(negedge clk);
      for (int c = 1; c < lat; c++) begin
         if (c > 1) @(negedge clk);
         chk("exec_busy", busy, 1'b1);
         chk("exec_in_ready", in_ready, 1'b0);
         chk("exec_no_wb", wb_valid, 1'b0);
         chk("exec_alu_a", alu_a, a);
         chk("exec_alu_b", alu_b, b);
         chk("exec_alu_func", alu_func, f);
         // Stray requests while busy must be ignored.
         in_valid = junk;
         in_a = $urandom; in_b = $urandom;
         in_func = 3'($urandom); in_rd = RW'($urandom);
      end
      @(negedge clk);
      in_valid = 1'b0;
      if (exp_wb) begin
         chk("wb_valid", wb_valid, 1'b1);
         chk("wb_rd", wb_rd, rd);
         chk("wb_data", wb_data, exp_data);
         chk("wb_in_ready", in_ready, 1'b0);
         chk("wb_flags", flags, exp_flags);
         for (int w = 0; w < wt; w++) begin
            @(negedge clk);
            chk("wb_hold_valid", wb_valid, 1'b1);
            chk("wb_hold_data", wb_data, exp_data);
            chk("wb_hold_in_ready", in_ready, 1'b0);
         end
         wb_ready = 1'b1;
         @(negedge clk);
         wb_ready = 1'b0;
         chk("wb_done_valid", wb_valid, 1'b0);
         chk("wb_done_in_ready", in_ready, 1'b1);
      end else begin
         chk("nowb_valid", wb_valid, 1'b0);
         chk("nowb_in_ready", in_ready, 1'b1);
         chk("nowb_busy", busy, 1'b0);
         chk("nowb_flags", flags, exp_flags);
      end
      chk("alu_a_hold", alu_a, a);
      chk("alu_func_hold", alu_func, f);
   endtask

   typedef struct {
      logic [2:0]    f;
      logic [DW-1:0] a, b;
      logic [RW-1:0] rd;
      int            wt;
      bit            exp_wb;
      logic [DW-1:0] exp_data;
      logic [1:0]    exp_flags;
   } vec_t;

   vec_t vecs[11];

   initial begin
      #2_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0]  = '{FN_ADD,   32'd5,       32'd7,       4'd3,  0, 1'b1, 32'd12,       2'b00};
      vecs[1]  = '{FN_CMP,   32'd4,       32'd9,       4'd1,  0, 1'b0, 32'd0,        2'b10};
      vecs[2]  = '{FN_CMP,   32'd9,       32'd9,       4'd1,  0, 1'b0, 32'd0,        2'b01};
      vecs[3]  = '{FN_AND,   32'hF0F0,    32'hFF00,    4'd2,  0, 1'b1, 32'hF000,     2'b01};
      vecs[4]  = '{FN_MUL,   32'h10000,   32'h10000,   4'd5,  0, 1'b1, 32'h0,        2'b01};
      vecs[5]  = '{FN_SUB,   32'd3,       32'd1,       4'd7,  5, 1'b1, 32'd2,        2'b01};
      vecs[6]  = '{FN_XOR,   32'hAA,      32'h55,      4'd0,  0, 1'b0, 32'd0,        2'b01};
      vecs[7]  = '{FN_SHL16, 32'h1234,    32'h9,       4'd15, 1, 1'b1, 32'h12340000, 2'b01};
      vecs[8]  = '{FN_OR,    32'h0F,      32'hF0,      4'd4,  0, 1'b1, 32'hFF,       2'b01};
      vecs[9]  = '{FN_MUL,   32'd3,       32'd5,       4'd6,  2, 1'b1, 32'd15,       2'b01};
      vecs[10] = '{FN_CMP,   32'd9,       32'd4,       4'd0,  0, 1'b0, 32'd0,        2'b00};

      rst_n = 1'b0; in_valid = 1'b0; in_func = '0; in_a = '0; in_b = '0; in_rd = '0;
      wb_ready = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_in_ready", in_ready, 1'b1);
      chk("rst_busy", busy, 1'b0);
      chk("rst_wb_valid", wb_valid, 1'b0);
      chk("rst_flags", flags, 2'b00);
      chk("rst_alu_a", alu_a, '0);
      chk("rst_wb_data", wb_data, '0);
      rst_n = 1'b1;

      // Directed vectors
      for (int i = 0; i < 11; i++)
         run_op(vecs[i].f, vecs[i].a, vecs[i].b, vecs[i].rd, vecs[i].wt, 1'b0,
                vecs[i].exp_wb, vecs[i].exp_data, vecs[i].exp_flags);
      mflags = 2'b00;

      // Reset during a MUL in EXEC, after flags were made nonzero
      run_op(FN_CMP, 32'd7, 32'd7, 4'd1, 0, 1'b0, 1'b0, 32'd0, FLG_ZERO);
      @(negedge clk);
      in_valid = 1'b1; in_func = FN_MUL; in_a = 32'd6; in_b = 32'd7; in_rd = 4'd2;
      @(negedge clk);
      in_valid = 1'b0;
      chk("mul_busy_before_rst", busy, 1'b1);
      #2 rst_n = 1'b0;
      #1;
      chk("midrst_busy", busy, 1'b0);
      chk("midrst_wb_valid", wb_valid, 1'b0);
      chk("midrst_flags", flags, 2'b00);
      chk("midrst_alu_a", alu_a, '0);
      // A request while reset is held is ignored
      @(negedge clk);
      in_valid = 1'b1; in_func = FN_ADD;
      @(posedge clk); #1;
      chk("rst_ignores_valid", busy, 1'b0);
      @(negedge clk);
      in_valid = 1'b0;
      rst_n = 1'b1;
      @(negedge clk);
      chk("post_rst_wb_valid", wb_valid, 1'b0);
      run_op(FN_ADD, 32'd100, 32'd23, 4'd9, 0, 1'b0, 1'b1, 32'd123, 2'b00);

      // Random stream against the reference model
      for (int n = 0; n < 200; n++) begin
         logic [2:0]    f;
         logic [DW-1:0] a, b;
         logic [RW-1:0] rd;
         bit            ewb;
         f  = 3'($urandom_range(0, 7));
         a  = $urandom;
         b  = ($urandom_range(0, 3) == 0) ? a : $urandom;
         if ($urandom_range(0, 1) == 1) begin
            a = DW'($urandom_range(0, 20)); b = DW'($urandom_range(0, 20));
         end
         rd  = RW'($urandom_range(0, 15));
         ewb = (f != FN_CMP) && (rd != 0);
         if (f == FN_CMP) mflags = flags_of(a - b);
         run_op(f, a, b, rd, $urandom_range(0, 3), 1'($urandom_range(0, 1)),
                ewb, ref_res(f, a, b), mflags);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
